// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length-prefixed little-endian byte stream -> 32-bit word writes.
// Optional trailing checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  cpu_hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam logic [31:0] CAPACITY = 32'd1 << (ADDR_WIDTH - 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE} state_t;
`endif

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           word_idx_q, word_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           buf_q, buf_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_waddr_q, mem_waddr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  logic        accept;
  logic [15:0] len_full;
  logic [15:0] word_idx_inc;

  assign rx_ready_o  = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                       || (state_q == CHK)
`endif
                       ;
  assign busy_o      = (state_q != IDLE);
  assign cpu_hold_o  = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign mem_we_o    = mem_we_q;
  assign mem_waddr_o = mem_waddr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign error_o     = error_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    buf_d        = buf_q;
    mem_we_d     = 1'b0;
    mem_waddr_d  = mem_waddr_q;
    mem_wdata_d  = mem_wdata_q;
    error_d      = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    accept       = rx_valid_i && rx_ready_o;
    len_full     = {rx_data_i, len_q[7:0]};
    word_idx_inc = word_idx_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = LEN_LO;
          error_d    = 1'b0;
          word_idx_d = '0;
          byte_idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d   = {8'h00, rx_data_i};
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == 16'd0) begin
            state_d = DONE;
          end else if ({16'd0, len_full} > CAPACITY) begin
            error_d = 1'b1;
            state_d = DONE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = sum_q + rx_data_i;
`endif
          if (byte_idx_q == 2'd3) begin
            // Top lane comes straight from the input so the word is written without an extra cycle.
            mem_wdata_d = DATA_WIDTH'({rx_data_i, buf_q});
            mem_waddr_d = ADDR_WIDTH'({word_idx_q, 2'b00});
            mem_we_d    = 1'b1;
            word_idx_d  = word_idx_inc;
            byte_idx_d  = '0;
            if (word_idx_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = CHK;
`else
              state_d = DONE;
`endif
            end
          end else begin
            case (byte_idx_q)
              2'd0:    buf_d[7:0]   = rx_data_i;
              2'd1:    buf_d[15:8]  = rx_data_i;
              default: buf_d[23:16] = rx_data_i;
            endcase
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          if (8'(sum_q + rx_data_i) != 8'd0) error_d = 1'b1;
          state_d = DONE;
        end
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      buf_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      buf_q       <= buf_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader that fills the instruction memory from a byte stream before the core is released. It sits between a byte source (UART receiver or test host) and the instruction memory's write port. It holds the core in reset while loading, assembles little-endian 32-bit words, and issues one write per word. It then signals completion or error.

## Interface
- ADDR_WIDTH, 10, byte-address width of instruction memory; capacity = 2^(ADDR_WIDTH-2) words
- DATA_WIDTH, 32, memory word width; only 32 is supported
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  begin a load; sampled only in IDLE
- rx_data_i  in  8  incoming byte
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  loader accepts byte; transfer when rx_valid_i & rx_ready_o
- mem_we_o  out  1  one-cycle write strobe
- mem_waddr_o  out  ADDR_WIDTH  byte address, always word-aligned (low 2 bits 0)
- mem_wdata_o  out  DATA_WIDTH  write data
- cpu_hold_o  out  1  keep core in reset while high
- busy_o  out  1  load in progress
- done_o  out  1  one-cycle pulse at end of load (success or error)
- error_o  out  1  sticky error, cleared on next accepted start_i

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, CHK (macro only), DONE.
- IDLE: rx_ready_o=0, busy_o=0, cpu_hold_o=0. start_i=1 → LEN_LO; clear error_o, word_idx, byte_idx, checksum.
- LEN_LO/LEN_HI: accept the 16-bit word count N, low byte first.
- After LEN_HI:
  - N=0 → DONE.
  - N > 2^(ADDR_WIDTH-2) → set error_o, → DONE, no writes.
  - Otherwise → DATA.
- DATA: each accepted byte is placed at lane byte_idx, little-endian (first byte = bits 7:0). On the 4th byte:
  - Register mem_wdata_o and mem_waddr_o = word_idx*4.
  - Pulse mem_we_o next cycle.
  - Increment word_idx and reset byte_idx to 0.
  - When word_idx reaches N → CHK if enabled, else DONE.
- DONE: done_o=1 for exactly one cycle, → IDLE.
- rx_ready_o=1 in LEN_LO, LEN_HI, DATA, CHK; 0 elsewhere. Bytes with rx_valid_i=0 are not consumed, and state holds.
- busy_o=1 and cpu_hold_o=1 in every state except IDLE.
- start_i outside IDLE is ignored.
- word_idx is 16 bits wide. The capacity check guarantees mem_waddr_o never wraps.

## Timing
- Reset values:
  - State IDLE.
  - rx_ready_o, mem_we_o, busy_o, done_o, error_o, cpu_hold_o all 0.
  - mem_waddr_o=0, mem_wdata_o=0.
- start_i in cycle t → rx_ready_o=1 in cycle t+1.
- Write latency: mem_we_o is high in the cycle after the 4th-byte handshake. rx_ready_o stays high, so a byte may be accepted in that same cycle.
- Minimum load time with continuous rx_valid_i: 1 + 2 + 4N (+1 CHK) + 1 cycles from start_i to done_o.
- mem_we_o never rises after done_o without a new start_i.
- Reset mid-load: all state and outputs return to reset values immediately (asynchronous). Partially assembled words are discarded, and no write is issued.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - An 8-bit running sum of all data bytes is kept, mod 256.
  - After the last word, CHK accepts one byte C.
  - If (sum + C) mod 256 ≠ 0, set error_o.
  - → DONE. Words already written are not rolled back.
  - When N=0, CHK is skipped.
- Not defined: no CHK state, no checksum logic; error_o is set only by overflow.

## Test plan
- start_i; bytes 02 00, 13 00 00 00, 93 00 10 00 → writes addr 0x000 data 0x00000013, then addr 0x004 data 0x00100093. done_o pulses; error_o=0; cpu_hold_o falls after DONE.
- Bytes 00 00 → no mem_we_o; done_o pulses 1 cycle after LEN_HI; error_o=0.
- ADDR_WIDTH=10, bytes 01 01 (N=257) → error_o=1, no writes, done_o pulses, back to IDLE. Next start_i clears error_o.
- N=1 with rx_valid_i deasserted for 3 cycles between each byte → single write, data assembled correctly; start_i pulsed mid-load has no effect.
- After 2 data bytes, assert rst_n=0 for 1 cycle → all outputs 0 immediately, no write. A fresh load then writes from addr 0.
- Checksum enabled, N=1, data 01 02 03 04:
  - Chk byte F6 → error_o=0.
  - Chk byte F7 → error_o=1; word still written.
